// File: rtl/timer_pkg.sv
// timer_pkg
// Shared definitions for the timing/control fabric timers.
//   timer_state_e : down_timer FSM state encoding (IDLE, RUN, EXPIRED)
//   DEFAULT_WIDTH : default count / load / reload register width
package timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Encodings are fixed so that state values stay stable across revisions.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } timer_state_e;

endpackage

// File: rtl/down_count_core.sv
// down_count_core
// Datapath for down_timer. Holds the count and reload registers, performs
// the saturating decrement and flags the ==1 / ==0 conditions.
// Ports:
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   rel_we, rel_din  : write enable / data for the reload register
//   cnt_we, cnt_din  : write enable / data for the count register (wins over dec)
//   dec              : decrement the count by one (ignored at zero)
//   count            : current count
//   reload_q         : current reload register value
//   at_one, at_zero  : count == 1, count == 0
module down_count_core
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rel_we,
  input  logic [WIDTH-1:0] rel_din,
  input  logic             cnt_we,
  input  logic [WIDTH-1:0] cnt_din,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] reload_q,
  output logic             at_one,
  output logic             at_zero
);

  assign at_zero = (count == '0);
  assign at_one  = (count == WIDTH'(1));

  // Count and reload registers. A direct write has priority over the
  // decrement, and the decrement is blocked at zero so the count can
  // never wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      reload_q <= '0;
    end else begin
      if (rel_we) begin
        reload_q <= rel_din;
      end
      if (cnt_we) begin
        count <= cnt_din;
      end else if (dec && !at_zero) begin
        count <= count - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/down_timer.sv
// down_timer
// Loadable down-counter/timer with one-shot and auto-reload modes.
// Ports:
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset
//   load        : capture load_val into the reload register (and the count
//                 when not running)
//   load_val    : value to load
//   start       : begin or resume counting
//   stop        : pause counting (beats start)
//   auto_reload : 1 = periodic, 0 = one-shot; sampled at each expiry
//   cout        : current count
//   busy        : high while running
//   tc          : one-cycle terminal-count pulse
//   done        : sticky one-shot expiry flag
module down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cout,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  timer_state_e     state;
  logic             rel_we;
  logic             cnt_we;
  logic             dec;
  logic [WIDTH-1:0] cnt_din;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload_q;
  logic             at_one;
  logic             at_zero;
  logic [WIDTH-1:0] eff_idle;
  logic [WIDTH-1:0] eff_exp;
  logic             expiring;

  // A same-cycle load is applied before start is judged, so start sees the
  // freshly loaded value rather than the stale register.
  assign eff_idle = load ? load_val : count;
  assign eff_exp  = load ? load_val : reload_q;

  // count <= 1 covers a zero reload in periodic mode: it re-expires every
  // cycle instead of trying to decrement below zero.
  assign expiring = at_one || at_zero;

  assign cout = count;
  assign busy = (state == RUN);

  down_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .rel_we   (rel_we),
    .rel_din  (load_val),
    .cnt_we   (cnt_we),
    .cnt_din  (cnt_din),
    .dec      (dec),
    .count    (count),
    .reload_q (reload_q),
    .at_one   (at_one),
    .at_zero  (at_zero)
  );

  // Datapath controls. A load always refreshes the reload register; it only
  // touches the running count outside RUN, so a load during RUN takes effect
  // at the next reload.
  always_comb begin
    rel_we  = load;
    cnt_we  = 1'b0;
    cnt_din = load_val;
    dec     = 1'b0;
    case (state)
      IDLE: begin
        cnt_we = load;
      end
      RUN: begin
        if (!stop) begin
          if (expiring) begin
            cnt_we  = 1'b1;
            cnt_din = auto_reload ? reload_q : '0;
          end else begin
            dec = 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (start) begin
          cnt_we  = 1'b1;
          cnt_din = eff_exp;
        end else if (load) begin
          cnt_we = 1'b1;
        end
      end
      default: begin
        cnt_we = 1'b0;
      end
    endcase
  end

  // Control FSM with registered tc/done. tc is a single-cycle pulse raised
  // only by an expiry edge; done is sticky until the next load or start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (eff_idle != '0) begin
              state <= RUN;
            end else begin
              state <= EXPIRED;
              tc    <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else if (expiring) begin
            tc <= 1'b1;
            if (!auto_reload) begin
              done  <= 1'b1;
              state <= EXPIRED;
            end
          end
        end
        EXPIRED: begin
          if (start) begin
            if (eff_exp != '0) begin
              state <= RUN;
              done  <= 1'b0;
            end else begin
              tc   <= 1'b1;
              done <= 1'b1;
            end
          end else if (load) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_down_timer.sv
// tb_down_timer
// Directed, self-checking bench for down_timer (WIDTH = 4). Each step drives
// the inputs, advances one rising edge and compares cout/busy/tc/done with
// hand-computed values.
module tb_down_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [3:0] cout;
  logic       busy;
  logic       tc;
  logic       done;

  int checkCount;
  int errorCount;

  down_timer #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .cout        (cout),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs, then advance past the next rising
  // edge so outputs are sampled 1 ns after it.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] val,
                               input logic st, input logic sp, input logic ar);
    reset       = rst;
    load        = ld;
    load_val    = val;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    @(posedge clk);
    #1;
  endtask

  // Compare all four outputs against the expected values in one check.
  task automatic checkOutput(input string tag, input logic [3:0] expCout,
                             input logic expBusy, input logic expTc, input logic expDone);
    checkCount++;
    assert (cout === expCout && busy === expBusy && tc === expTc && done === expDone)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: cout/busy/tc/done got %0d/%0b/%0b/%0b need %0d/%0b/%0b/%0b",
             tag, cout, busy, tc, done, expCout, expBusy, expTc, expDone);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; stop = 1'b0; auto_reload = 1'b0;

    // Reset held for two edges, then released.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset", 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("idle_after_reset", 4'd0, 0, 0, 0);

    // One-shot from 5.
    applyStimulus(0, 1, 4'd5, 0, 0, 0);
    checkOutput("os_load5", 4'd5, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("os_start", 4'd5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("os_count", 4'(i), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("os_expire", 4'd0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("os_tc_one_cycle", 4'd0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("stop_in_expired", 4'd0, 0, 0, 1);

    // Auto-reload at 3 for four periods, then one-shot exit.
    applyStimulus(0, 1, 4'd3, 0, 0, 0);
    checkOutput("ar_load3_from_expired", 4'd3, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("ar_start", 4'd3, 1, 0, 0);
    for (int p = 0; p < 4; p++) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("ar_two", 4'd2, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("ar_one", 4'd1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("ar_reload", 4'd3, 1, 1, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ar_drop_two", 4'd2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ar_drop_one", 4'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ar_drop_expire", 4'd0, 0, 1, 1);

    // Pause at 6, hold four cycles, resume; nine RUN edges in total.
    applyStimulus(0, 1, 4'd9, 0, 0, 0);
    checkOutput("pr_load9", 4'd9, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pr_start", 4'd9, 1, 0, 0);
    for (int i = 8; i >= 6; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pr_count", 4'(i), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("pr_stop", 4'd6, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pr_hold", 4'd6, 0, 0, 0);
    end
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pr_resume", 4'd6, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_in_run_ignored", 4'd5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("pr_count2", 4'(i), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("pr_expire", 4'd0, 0, 1, 1);

    // Zero load with start in IDLE expires immediately.
    applyStimulus(0, 1, 4'd0, 0, 0, 0);
    checkOutput("zero_load_to_idle", 4'd0, 0, 0, 0);
    applyStimulus(0, 1, 4'd0, 1, 0, 0);
    checkOutput("zero_load_start", 4'd0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("zero_after", 4'd0, 0, 0, 1);

    // start + stop in RUN goes to IDLE; stop in IDLE does nothing.
    applyStimulus(0, 1, 4'd4, 0, 0, 0);
    checkOutput("ss_load4", 4'd4, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("ss_start", 4'd4, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("ss_stop_beats_start", 4'd4, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("stop_in_idle", 4'd4, 0, 0, 0);

    // Load 7 while running at cout = 2: the next reload uses 7.
    applyStimulus(0, 0, 0, 1, 0, 1);
    checkOutput("rl_start", 4'd4, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rl_three", 4'd3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rl_two", 4'd2, 1, 0, 0);
    applyStimulus(0, 1, 4'd7, 0, 0, 1);
    checkOutput("rl_load_in_run", 4'd1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("rl_reload7", 4'd7, 1, 1, 0);
    for (int i = 6; i >= 3; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("rl_count", 4'(i), 1, 0, 0);
    end

    // Reset while running at cout = 3 aborts without tc and clears reload.
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("reset_mid_run", 4'd0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("start_after_reset_zero", 4'd0, 0, 1, 1);

    // Full-scale one-shot from 15, then restart from EXPIRED.
    applyStimulus(0, 1, 4'd15, 0, 0, 0);
    checkOutput("fs_load15", 4'd15, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("fs_start", 4'd15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("fs_count", 4'(i), 1, 0, 0);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("fs_expire", 4'd0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("fs_restart", 4'd15, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("fs_restart_dec", 4'd14, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
